// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the pixel-colour stages.
// Free-running h/v counters advance on pix_en; every output is registered from
// the pre-increment counter values, so outputs trail the counters by one pixel.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   pix_en        pixel-clock enable (one pixel per clk with pix_en=1)
//   pix_x, pix_y  current column/row, forced to 0 outside the active area
//   pix_v         pixel is inside the active area
//   hsync, vsync  display sync pins, asserted level = SYNC_POL
//   frame_start   one-clk pulse when the output pixel is (0,0)
//   frame_cnt     16-bit frame counter, only when VGA_FRAME_CNT_EN is defined
//
// Optional feature macro: VGA_FRAME_CNT_EN (adds frame_cnt).
module vga_timing_gen #(
  parameter int unsigned pA       = 10,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [pA-1:0] pix_x,
  output logic [pA-1:0] pix_y,
  output logic          pix_v,
  output logic          hsync,
  output logic          vsync,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [pA-1:0] H_LAST = pA'(H_TOTAL - 1);
  localparam logic [pA-1:0] V_LAST = pA'(V_TOTAL - 1);

  // Counters must be able to hold every position of the raster.
  if (64'(H_TOTAL) > (64'd1 << pA)) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL does not fit in pA bits");
  end
  if (64'(V_TOTAL) > (64'd1 << pA)) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL does not fit in pA bits");
  end

  logic [pA-1:0] h_cnt_q, h_cnt_d;
  logic [pA-1:0] v_cnt_q, v_cnt_d;
  logic [pA-1:0] pix_x_q, pix_x_d;
  logic [pA-1:0] pix_y_q, pix_y_d;
  logic          pix_v_q, pix_v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d;
  logic [31:0]   h_ext, v_ext;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          seen_frame_q, seen_frame_d;
`endif

  // Next-state: counter advance and output decode from pre-increment counters.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_v_d       = pix_v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
`ifdef VGA_FRAME_CNT_EN
    frame_cnt_d   = frame_cnt_q;
    seen_frame_d  = seen_frame_q;
`endif
    // Compare in 32 bits so sync-end bounds equal to 2**pA do not truncate.
    h_ext = 32'(h_cnt_q);
    v_ext = 32'(v_cnt_q);

    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + pA'(1);
      end else begin
        h_cnt_d = h_cnt_q + pA'(1);
      end

      pix_v_d       = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
      pix_x_d       = pix_v_d ? h_cnt_q : '0;
      pix_y_d       = pix_v_d ? v_cnt_q : '0;
      hsync_d       = ((h_ext >= HS_START) && (h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
      // vsync spans whole lines, independent of h_cnt.
      vsync_d       = ((v_ext >= VS_START) && (v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

`ifdef VGA_FRAME_CNT_EN
      // The first frame after reset is frame 0, so skip its increment.
      if (frame_start_d) begin
        if (seen_frame_q) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
        seen_frame_d = 1'b1;
      end
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_v_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= 16'd0;
      seen_frame_q  <= 1'b0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_v_q       <= pix_v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt_q   <= frame_cnt_d;
      seen_frame_q  <= seen_frame_d;
`endif
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_v       = pix_v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one instance at default 640x480 timing and one
// small-raster instance (H 4/1/2/1, V 3/1/1/1, 8x6 total) sharing clk/rst_n.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [31:0] tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        v;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] fc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en_d = 1'b0;
  logic en_s = 1'b0;

  logic [9:0] x_d, y_d, x_s, y_s;
  logic       v_d, hs_d, vs_d, fs_d;
  logic       v_s, hs_s, vs_s, fs_s;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_d, fc_s;
`endif

  int total = 0;
  int bad = 0;
  int tick_d = 0;
  int tick_s = 0;
  int hs_low = 0;
  int vs_low = 0;

  vec_t vec_d[11];
  vec_t vec_s[18];

  localparam logic [23:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .pix_en(en_d),
    .pix_x(x_d), .pix_y(y_d), .pix_v(v_d), .hsync(hs_d), .vsync(vs_d),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc_d),
`endif
    .frame_start(fs_d)
  );

  vga_timing_gen #(
    .pA(10), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(en_s),
    .pix_x(x_s), .pix_y(y_s), .pix_v(v_s), .hsync(hs_s), .vsync(vs_s),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc_s),
`endif
    .frame_start(fs_s)
  );

  wire [23:0] got_d = {x_d, y_d, v_d, hs_d, vs_d, fs_d};
  wire [23:0] got_s = {x_s, y_s, v_s, hs_s, vs_s, fs_s};

  function automatic vec_t mk(int t, int x, int y, bit v, bit hs, bit vs, bit fs, int fc);
    vec_t r;
    r.tick = 32'(t); r.x = 10'(x); r.y = 10'(y);
    r.v = v; r.hs = hs; r.vs = vs; r.fs = fs; r.fc = 16'(fc);
    return r;
  endfunction

  function automatic logic [23:0] exp_vec(vec_t e);
    return {e.x, e.y, e.v, e.hs, e.vs, e.fs};
  endfunction

  // Small raster expectation for tick n (n>=1 presents pixel n-1).
  function automatic logic [23:0] exp_s(int n);
    int p, h, v;
    bit pv;
    if (n == 0) return RST_VEC;
    p  = n - 1;
    h  = p % 8;
    v  = (p / 8) % 6;
    pv = (h < 4) && (v < 3);
    return {10'(pv ? h : 0), 10'(pv ? v : 0), pv,
            !((h >= 5) && (h < 7)), !(v == 4), (h == 0) && (v == 0)};
  endfunction

  task automatic check(input string name, input int t, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s tick=%0d got x=%0d y=%0d v/hs/vs/fs=%b%b%b%b want x=%0d y=%0d v/hs/vs/fs=%b%b%b%b",
               name, t, got[23:14], got[13:4], got[3], got[2], got[1], got[0],
               exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_n(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Advance the default instance to the given tick, counting hsync-low ticks of line 0.
  task automatic adv_d(input int target);
    while (tick_d < target) begin
      en_d = 1'b1;
      @(posedge clk); #1;
      tick_d++;
      if (tick_d <= 800 && hs_d == 1'b0) hs_low++;
    end
  endtask

  // Advance the small instance; with half=1 an idle clk precedes every tick.
  task automatic adv_s(input int target, input bit half);
    while (tick_s < target) begin
      if (half) begin
        en_s = 1'b0;
        @(posedge clk); #1;
        check("idle_hold", tick_s, got_s, exp_s(tick_s) & ~24'd1);
      end
      en_s = 1'b1;
      @(posedge clk); #1;
      tick_s++;
      check("small_tick", tick_s, got_s, exp_s(tick_s));
      if (tick_s <= 48 && vs_s == 1'b0) vs_low++;
    end
  endtask

  task automatic run_small(input bit half, input string tag);
    vs_low = 0;
    for (int i = 0; i < 18; i++) begin
      adv_s(int'(vec_s[i].tick), half);
      check(tag, tick_s, got_s, exp_vec(vec_s[i]));
`ifdef VGA_FRAME_CNT_EN
      check_n({tag, "_fc"}, int'(fc_s), int'(vec_s[i].fc));
`endif
    end
    check_n({tag, "_vs_low"}, vs_low, 8);
    en_s = 1'b0;
  endtask

  initial begin
    // tick, x, y, v, hs, vs, fs, frame_cnt
    vec_d[0]  = mk(1,   0,   0, 1, 1, 1, 1, 0);
    vec_d[1]  = mk(2,   1,   0, 1, 1, 1, 0, 0);
    vec_d[2]  = mk(640, 639, 0, 1, 1, 1, 0, 0);
    vec_d[3]  = mk(641, 0,   0, 0, 1, 1, 0, 0);
    vec_d[4]  = mk(656, 0,   0, 0, 1, 1, 0, 0);
    vec_d[5]  = mk(657, 0,   0, 0, 0, 1, 0, 0);
    vec_d[6]  = mk(752, 0,   0, 0, 0, 1, 0, 0);
    vec_d[7]  = mk(753, 0,   0, 0, 1, 1, 0, 0);
    vec_d[8]  = mk(800, 0,   0, 0, 1, 1, 0, 0);
    vec_d[9]  = mk(801, 0,   1, 1, 1, 1, 0, 0);
    vec_d[10] = mk(802, 1,   1, 1, 1, 1, 0, 0);

    vec_s[0]  = mk(1,   0, 0, 1, 1, 1, 1, 0);
    vec_s[1]  = mk(4,   3, 0, 1, 1, 1, 0, 0);
    vec_s[2]  = mk(5,   0, 0, 0, 1, 1, 0, 0);
    vec_s[3]  = mk(6,   0, 0, 0, 0, 1, 0, 0);
    vec_s[4]  = mk(7,   0, 0, 0, 0, 1, 0, 0);
    vec_s[5]  = mk(8,   0, 0, 0, 1, 1, 0, 0);
    vec_s[6]  = mk(9,   0, 1, 1, 1, 1, 0, 0);
    vec_s[7]  = mk(20,  3, 2, 1, 1, 1, 0, 0);
    vec_s[8]  = mk(24,  0, 0, 0, 1, 1, 0, 0);
    vec_s[9]  = mk(25,  0, 0, 0, 1, 1, 0, 0);
    vec_s[10] = mk(33,  0, 0, 0, 1, 0, 0, 0);
    vec_s[11] = mk(40,  0, 0, 0, 1, 0, 0, 0);
    vec_s[12] = mk(41,  0, 0, 0, 1, 1, 0, 0);
    vec_s[13] = mk(48,  0, 0, 0, 1, 1, 0, 0);
    vec_s[14] = mk(49,  0, 0, 1, 1, 1, 1, 1);
    vec_s[15] = mk(50,  1, 0, 1, 1, 1, 0, 1);
    vec_s[16] = mk(97,  0, 0, 1, 1, 1, 1, 2);
    vec_s[17] = mk(145, 0, 0, 1, 1, 1, 1, 3);

    // Reset state.
    #2 rst_n = 1'b0;
    #20;
    check("reset_d", 0, got_d, RST_VEC);
    check("reset_s", 0, got_s, RST_VEC);
`ifdef VGA_FRAME_CNT_EN
    check_n("reset_fc", int'(fc_d), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    en_d = 1'b1;

    // Default timing table.
    for (int i = 0; i < 11; i++) begin
      adv_d(int'(vec_d[i].tick));
      check("default", tick_d, got_d, exp_vec(vec_d[i]));
`ifdef VGA_FRAME_CNT_EN
      check_n("default_fc", int'(fc_d), int'(vec_d[i].fc));
`endif
    end
    check_n("hsync_low_ticks", hs_low, 96);

    // Mid-line asynchronous reset at h=300, v=1.
    adv_d(1101);
    check("pre_reset", tick_d, got_d, {10'd300, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check("async_reset", tick_d, got_d, RST_VEC);
    @(posedge clk); #1;
    check("held_reset", tick_d, got_d, RST_VEC);
    rst_n = 1'b1;
    tick_d = 0;
    adv_d(1);
    check("after_reset", tick_d, got_d, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1});
    adv_d(2);
    check("after_reset_fs_drop", tick_d, got_d, {10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    en_d = 1'b0;

    // Small raster, pix_en tied high.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick_s = 0;
    run_small(1'b0, "small_full");

    // Small raster, pix_en every second clk.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick_s = 0;
    run_small(1'b1, "small_half");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
